// File: rtl/bus_arbiter.sv
// Two-port round-robin memory arbiter: port A read-only fetch, port B read/write data.
// Read returns are steered back to their owner through a LATENCY-deep tag pipeline.
module bus_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        a_req_in,
  input  logic [31:0] a_addr_in,
  output logic        a_gnt_out,
  output logic        a_rvalid_out,
  output logic [31:0] a_rdata_out,
  input  logic        b_req_in,
  input  logic        b_we_in,
  input  logic [31:0] b_addr_in,
  input  logic [31:0] b_wdata_in,
  input  logic [3:0]  b_wstrb_in,
  output logic        b_gnt_out,
  output logic        b_rvalid_out,
  output logic [31:0] b_rdata_out,
  output logic        mem_en_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wstrb_out,
  input  logic [31:0] mem_rdata_in
);

  logic               last_b_q, last_b_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_b_q, tag_b_d;
  logic               sel_b;
  logic               a_gnt, b_gnt, rd_gnt;
  logic               ret_vld, ret_b;

  // B wins only when alone, or when A also asks but A was served last.
  always_comb begin
    sel_b   = b_req_in && (!a_req_in || !last_b_q);
    a_gnt   = rst_in && a_req_in && !sel_b;
    b_gnt   = rst_in && b_req_in && sel_b;
    rd_gnt  = a_gnt || (b_gnt && !b_we_in);
    ret_vld = rst_in && tag_vld_q[LATENCY-1];
    ret_b   = tag_b_q[LATENCY-1];
  end

  always_comb begin
    a_gnt_out     = a_gnt;
    b_gnt_out     = b_gnt;
    mem_en_out    = a_gnt || b_gnt;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    mem_wstrb_out = '0;
    if (a_gnt) begin
      mem_addr_out = a_addr_in;
    end else if (b_gnt) begin
      mem_addr_out  = b_addr_in;
      mem_we_out    = b_we_in;
      mem_wdata_out = b_wdata_in;
      mem_wstrb_out = b_we_in ? b_wstrb_in : 4'b0000;
    end
  end

  always_comb begin
    a_rvalid_out = ret_vld && !ret_b;
    b_rvalid_out = ret_vld && ret_b;
    a_rdata_out  = a_rvalid_out ? mem_rdata_in : 32'h0;
    b_rdata_out  = b_rvalid_out ? mem_rdata_in : 32'h0;
  end

  // Writes still occupy a slot (valid=0) so the return schedule stays in grant order.
  always_comb begin
    last_b_d = last_b_q;
    if (a_gnt) begin
      last_b_d = 1'b0;
    end else if (b_gnt) begin
      last_b_d = 1'b1;
    end
    tag_vld_d    = tag_vld_q;
    tag_b_d      = tag_b_q;
    tag_vld_d[0] = rd_gnt;
    tag_b_d[0]   = b_gnt;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_b_d[i]   = tag_b_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      last_b_q  <= 1'b1;
      tag_vld_q <= '0;
      tag_b_q   <= '0;
    end else begin
      last_b_q  <= last_b_d;
      tag_vld_q <= tag_vld_d;
      tag_b_q   <= tag_b_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed checks on a LATENCY=2 arbiter plus a random scoreboard sweep on LATENCY=1 and 4.
// All three instances share request inputs; each has its own behavioural memory.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst0, rst_s;
  logic        a_req, b_req, b_we;
  logic [31:0] a_addr, b_addr, b_wdata;
  logic [3:0]  b_wstrb;

  logic        d0_a_gnt, d0_a_rv, d0_b_gnt, d0_b_rv, d0_en, d0_we;
  logic [31:0] d0_a_rd, d0_b_rd, d0_addr, d0_wdata, d0_rdata;
  logic [3:0]  d0_wstrb;
  logic        d1_a_gnt, d1_a_rv, d1_b_gnt, d1_b_rv, d1_en, d1_we;
  logic [31:0] d1_a_rd, d1_b_rd, d1_addr, d1_wdata, d1_rdata;
  logic [3:0]  d1_wstrb;
  logic        d4_a_gnt, d4_a_rv, d4_b_gnt, d4_b_rv, d4_en, d4_we;
  logic [31:0] d4_a_rd, d4_b_rd, d4_addr, d4_wdata, d4_rdata;
  logic [3:0]  d4_wstrb;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.LATENCY(2)) u_d0 (
    .clk_in(clk), .rst_in(rst0),
    .a_req_in(a_req), .a_addr_in(a_addr), .a_gnt_out(d0_a_gnt),
    .a_rvalid_out(d0_a_rv), .a_rdata_out(d0_a_rd),
    .b_req_in(b_req), .b_we_in(b_we), .b_addr_in(b_addr), .b_wdata_in(b_wdata),
    .b_wstrb_in(b_wstrb), .b_gnt_out(d0_b_gnt), .b_rvalid_out(d0_b_rv), .b_rdata_out(d0_b_rd),
    .mem_en_out(d0_en), .mem_we_out(d0_we), .mem_addr_out(d0_addr),
    .mem_wdata_out(d0_wdata), .mem_wstrb_out(d0_wstrb), .mem_rdata_in(d0_rdata));

  bus_arbiter #(.LATENCY(1)) u_d1 (
    .clk_in(clk), .rst_in(rst_s),
    .a_req_in(a_req), .a_addr_in(a_addr), .a_gnt_out(d1_a_gnt),
    .a_rvalid_out(d1_a_rv), .a_rdata_out(d1_a_rd),
    .b_req_in(b_req), .b_we_in(b_we), .b_addr_in(b_addr), .b_wdata_in(b_wdata),
    .b_wstrb_in(b_wstrb), .b_gnt_out(d1_b_gnt), .b_rvalid_out(d1_b_rv), .b_rdata_out(d1_b_rd),
    .mem_en_out(d1_en), .mem_we_out(d1_we), .mem_addr_out(d1_addr),
    .mem_wdata_out(d1_wdata), .mem_wstrb_out(d1_wstrb), .mem_rdata_in(d1_rdata));

  bus_arbiter #(.LATENCY(4)) u_d4 (
    .clk_in(clk), .rst_in(rst_s),
    .a_req_in(a_req), .a_addr_in(a_addr), .a_gnt_out(d4_a_gnt),
    .a_rvalid_out(d4_a_rv), .a_rdata_out(d4_a_rd),
    .b_req_in(b_req), .b_we_in(b_we), .b_addr_in(b_addr), .b_wdata_in(b_wdata),
    .b_wstrb_in(b_wstrb), .b_gnt_out(d4_b_gnt), .b_rvalid_out(d4_b_rv), .b_rdata_out(d4_b_rd),
    .mem_en_out(d4_en), .mem_we_out(d4_we), .mem_addr_out(d4_addr),
    .mem_wdata_out(d4_wdata), .mem_wstrb_out(d4_wstrb), .mem_rdata_in(d4_rdata));

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'h5A5A_0000);
  endfunction

  // Memories return read data a fixed number of cycles after a read enable, junk otherwise.
  logic [31:0] m0_addr [4];
  logic [31:0] m1_addr [4];
  logic [31:0] m4_addr [4];
  logic [3:0]  m0_en = '0, m1_en = '0, m4_en = '0;

  always @(posedge clk) begin
    m0_addr[0] <= d0_addr;
    m1_addr[0] <= d1_addr;
    m4_addr[0] <= d4_addr;
    for (int i = 1; i < 4; i++) begin
      m0_addr[i] <= m0_addr[i-1];
      m1_addr[i] <= m1_addr[i-1];
      m4_addr[i] <= m4_addr[i-1];
    end
    m0_en <= {m0_en[2:0], d0_en & ~d0_we};
    m1_en <= {m1_en[2:0], d1_en & ~d1_we};
    m4_en <= {m4_en[2:0], d4_en & ~d4_we};
  end

  assign d0_rdata = m0_en[1] ? mem_fn(m0_addr[1]) : 32'hBAD0_BAD0;
  assign d1_rdata = m1_en[0] ? mem_fn(m1_addr[0]) : 32'hBAD1_BAD1;
  assign d4_rdata = m4_en[3] ? mem_fn(m4_addr[3]) : 32'hBAD4_BAD4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
  endtask

  logic        lb, ega, egb, rd;
  logic [31:0] gaddr, exa, exb;
  logic        e1_v [320];
  logic        e1_b [320];
  logic [31:0] e1_a [320];
  logic        e4_v [320];
  logic        e4_b [320];
  logic [31:0] e4_a [320];

  initial begin
    for (int i = 0; i < 320; i++) begin
      e1_v[i] = 1'b0; e1_b[i] = 1'b0; e1_a[i] = '0;
      e4_v[i] = 1'b0; e4_b[i] = 1'b0; e4_a[i] = '0;
    end
    rst0 = 1'b0; rst_s = 1'b0;
    idle();
    a_req = 1'b1; b_req = 1'b1; a_addr = 32'h10; b_addr = 32'h20;

    // Reset forces everything quiet even with both ports requesting.
    step(); step();
    chk("rst_a_gnt", 32'(d0_a_gnt), 0);
    chk("rst_b_gnt", 32'(d0_b_gnt), 0);
    chk("rst_mem_en", 32'(d0_en), 0);
    chk("rst_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);
    chk("rst_a_rdata", d0_a_rd, 0);
    chk("rst_b_rdata", d0_b_rd, 0);

    // Single A read of 0x100.
    step(); rst0 = 1'b1; idle(); a_req = 1'b1; a_addr = 32'h100; #1;
    chk("sr_a_gnt", 32'(d0_a_gnt), 1);
    chk("sr_b_gnt", 32'(d0_b_gnt), 0);
    chk("sr_mem_en", 32'(d0_en), 1);
    chk("sr_mem_addr", d0_addr, 32'h100);
    chk("sr_mem_we", 32'(d0_we), 0);
    chk("sr_mem_wstrb", 32'(d0_wstrb), 0);
    step(); idle(); #1;
    chk("sr_c1_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);
    chk("sr_c1_mem_en", 32'(d0_en), 0);
    chk("sr_c1_mem_addr", d0_addr, 0);
    step();
    chk("sr_c2_a_rvalid", 32'(d0_a_rv), 1);
    chk("sr_c2_a_rdata", d0_a_rd, 32'h13);
    chk("sr_c2_b_rvalid", 32'(d0_b_rv), 0);

    // B write.
    step(); b_req = 1'b1; b_we = 1'b1; b_addr = 32'h2000; b_wdata = 32'hDEAD_BEEF;
    b_wstrb = 4'b0011; #1;
    chk("wr_b_gnt", 32'(d0_b_gnt), 1);
    chk("wr_mem_we", 32'(d0_we), 1);
    chk("wr_mem_addr", d0_addr, 32'h2000);
    chk("wr_mem_wdata", d0_wdata, 32'hDEAD_BEEF);
    chk("wr_mem_wstrb", 32'(d0_wstrb), 32'h3);
    for (int i = 0; i < 3; i++) begin
      step(); idle(); #1;
      chk("wr_no_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);
    end

    // Mixed stream: A read, B write, B read.
    step(); idle(); a_req = 1'b1; a_addr = 32'h40; #1;
    chk("mx_g0_a_gnt", 32'(d0_a_gnt), 1);
    step(); idle(); b_req = 1'b1; b_we = 1'b1; b_addr = 32'h44; b_wdata = 32'h1; b_wstrb = 4'hF; #1;
    chk("mx_g1_b_gnt", 32'(d0_b_gnt), 1);
    chk("mx_g1_mem_en", 32'(d0_en), 1);
    chk("mx_g1_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);
    step(); idle(); b_req = 1'b1; b_addr = 32'h48; #1;
    chk("mx_g2_b_gnt", 32'(d0_b_gnt), 1);
    chk("mx_g2_mem_en", 32'(d0_en), 1);
    chk("mx_g2_rvalid", 32'({d0_a_rv, d0_b_rv}), 32'h2);
    chk("mx_g2_a_rdata", d0_a_rd, mem_fn(32'h40));
    step(); idle(); #1;
    chk("mx_g3_mem_en", 32'(d0_en), 0);
    chk("mx_g3_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);
    step();
    chk("mx_g4_rvalid", 32'({d0_a_rv, d0_b_rv}), 32'h1);
    chk("mx_g4_b_rdata", d0_b_rd, mem_fn(32'h48));
    chk("mx_g4_a_rdata", d0_a_rd, 0);
    step();
    chk("mx_g5_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);

    // Reset while an A read is in flight.
    step(); idle(); a_req = 1'b1; a_addr = 32'h80; #1;
    chk("rm_a_gnt", 32'(d0_a_gnt), 1);
    step(); idle(); rst0 = 1'b0; #1;
    chk("rm_r1_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);
    step(); rst0 = 1'b1; #1;
    chk("rm_r2_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);

    // Continuous conflict after reset: A first, then alternating.
    for (int k = 0; k < 10; k++) begin
      step(); idle();
      if (k < 8) begin
        a_req = 1'b1; b_req = 1'b1;
        a_addr = 32'h1000 + 32'(4 * k);
        b_addr = 32'h3000 + 32'(4 * k);
      end
      #1;
      chk("cf_a_gnt", 32'(d0_a_gnt), 32'(k < 8 && k % 2 == 0));
      chk("cf_b_gnt", 32'(d0_b_gnt), 32'(k < 8 && k % 2 == 1));
      if (k >= 2) begin
        exa = ((k - 2) % 2 == 0) ? mem_fn(32'h1000 + 32'(4 * (k - 2))) : 32'h0;
        exb = ((k - 2) % 2 == 1) ? mem_fn(32'h3000 + 32'(4 * (k - 2))) : 32'h0;
        chk("cf_a_rvalid", 32'(d0_a_rv), 32'((k - 2) % 2 == 0));
        chk("cf_b_rvalid", 32'(d0_b_rv), 32'((k - 2) % 2 == 1));
        chk("cf_a_rdata", d0_a_rd, exa);
        chk("cf_b_rdata", d0_b_rd, exb);
      end else begin
        chk("cf_early_rvalid", 32'({d0_a_rv, d0_b_rv}), 0);
      end
    end

    // Random traffic on LATENCY=1 and LATENCY=4 against a round-robin scoreboard.
    lb = 1'b1;
    for (int n = 0; n < 300; n++) begin
      step();
      rst_s   = 1'b1;
      a_req   = 1'($urandom_range(0, 1));
      b_req   = 1'($urandom_range(0, 1));
      b_we    = 1'($urandom_range(0, 1));
      a_addr  = $urandom & 32'hFFFC;
      b_addr  = $urandom & 32'hFFFC;
      b_wdata = $urandom;
      b_wstrb = 4'($urandom_range(0, 15));
      #1;
      ega = a_req && (!b_req || lb);
      egb = b_req && !ega;
      chk("sw1_a_gnt", 32'(d1_a_gnt), 32'(ega));
      chk("sw1_b_gnt", 32'(d1_b_gnt), 32'(egb));
      chk("sw4_a_gnt", 32'(d4_a_gnt), 32'(ega));
      chk("sw4_b_gnt", 32'(d4_b_gnt), 32'(egb));
      chk("sw1_mem_we", 32'(d1_we), 32'(egb && b_we));
      chk("sw4_mem_we", 32'(d4_we), 32'(egb && b_we));
      chk("sw1_mem_wdata", d1_wdata, egb ? b_wdata : 32'h0);
      chk("sw4_mem_wdata", d4_wdata, egb ? b_wdata : 32'h0);
      if (!(egb && !b_we)) begin
        chk("sw1_mem_wstrb", 32'(d1_wstrb), egb ? 32'(b_wstrb) : 32'h0);
        chk("sw4_mem_wstrb", 32'(d4_wstrb), egb ? 32'(b_wstrb) : 32'h0);
      end
      if (ega) lb = 1'b0;
      else if (egb) lb = 1'b1;
      rd    = ega || (egb && !b_we);
      gaddr = ega ? a_addr : b_addr;
      if (rd) begin
        e1_v[n+1] = 1'b1; e1_b[n+1] = egb; e1_a[n+1] = gaddr;
        e4_v[n+4] = 1'b1; e4_b[n+4] = egb; e4_a[n+4] = gaddr;
      end
      chk("sw1_a_rvalid", 32'(d1_a_rv), 32'(e1_v[n] && !e1_b[n]));
      chk("sw1_b_rvalid", 32'(d1_b_rv), 32'(e1_v[n] && e1_b[n]));
      chk("sw1_a_rdata", d1_a_rd, (e1_v[n] && !e1_b[n]) ? mem_fn(e1_a[n]) : 32'h0);
      chk("sw1_b_rdata", d1_b_rd, (e1_v[n] && e1_b[n]) ? mem_fn(e1_a[n]) : 32'h0);
      chk("sw4_a_rvalid", 32'(d4_a_rv), 32'(e4_v[n] && !e4_b[n]));
      chk("sw4_b_rvalid", 32'(d4_b_rv), 32'(e4_v[n] && e4_b[n]));
      chk("sw4_a_rdata", d4_a_rd, (e4_v[n] && !e4_b[n]) ? mem_fn(e4_a[n]) : 32'h0);
      chk("sw4_b_rdata", d4_b_rd, (e4_v[n] && e4_b[n]) ? mem_fn(e4_a[n]) : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
